// File: rtl/seg_pkg.sv
// Purpose: shared constants and types for the 7-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: active-low hex->segment table, blank/off codes, digit-index type.
package seg_pkg;

   // Segment word is {g,f,e,d,c,b,a}, active-low (0 = lit).
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] dig_idx_t;

   // Entry n is the pattern for hex value n; the highest entry is listed first.
   localparam logic [15:0][6:0] HEX_SEG_TBL = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: decode one hex nibble to an active-low 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit value in), seg (7-bit active-low pattern out, seg[0]=a).
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TBL[hex];

endmodule

// File: rtl/seg_scan_mux.sv
// Purpose: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Latency: outputs registered one cycle after the internal slot counters.
// Backpressure: none; a new load overwrites un-transferred pending data.
// Ports: CLOCK, RESET (sync, active-high); load/digits/dp_mask/blank_mask in;
//        load_ack, frame_done pulses out; an/seg/dp active-low display drive.
// Optional: define SEG_DIM_EN to add dim_level[3:0] PWM brightness control.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 16
)(
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        load,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blank_mask,
`ifdef SEG_DIM_EN
   input  logic [3:0]  dim_level,
`endif
   output logic        load_ack,
   output logic        frame_done,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   dig_idx_t         idx;
   logic             pend;

   logic [15:0] pend_digits, act_digits;
   logic [3:0]  pend_dp,     act_dp;
   logic [3:0]  pend_blank,  act_blank;

   logic        tick;
   logic        boundary;
   logic        guard;
   logic        dim_on;
   logic [3:0]  cur_dig;
   logic [6:0]  dec_seg;
   logic [3:0]  an_nxt;
   logic [6:0]  seg_nxt;
   logic        dp_nxt;

   assign tick     = (div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign boundary = tick && (idx == 2'd3);
   assign guard    = (div_cnt < DIV_W'(GUARD_CYC));
   assign cur_dig  = act_digits[{idx, 2'b00} +: 4];

`ifdef SEG_DIM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge CLOCK) begin
      if (RESET) pwm_cnt <= 4'd0;
      else       pwm_cnt <= pwm_cnt + 4'd1;
   end

   // Live (unbuffered) brightness: anode on for dim_level+1 of every 16 cycles.
   assign dim_on = (pwm_cnt <= dim_level);
`else
   assign dim_on = 1'b1;
`endif

   hex_to_seg7 u_dec (
      .hex (cur_dig),
      .seg (dec_seg)
   );

   // Guard and dimming only gate the anode; blanking also kills segments and DP.
   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = dec_seg;
      dp_nxt  = ~act_dp[idx];
      if (act_blank[idx]) begin
         seg_nxt = SEG_BLANK;
         dp_nxt  = 1'b1;
      end else if (!guard && dim_on) begin
         an_nxt = ~(4'b0001 << idx);
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         div_cnt     <= '0;
         idx         <= 2'd0;
         pend        <= 1'b0;
         pend_digits <= 16'h0000;
         pend_dp     <= 4'h0;
         pend_blank  <= 4'h0;
         act_digits  <= 16'h0000;
         act_dp      <= 4'h0;
         act_blank   <= AN_OFF;
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
         load_ack    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) idx <= idx + 2'd1;

         // Transfer reads the pre-edge pending copy, so a load landing on the
         // boundary is kept for the next frame rather than lost.
         if (boundary && pend) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
         end

         if (load) begin
            pend_digits <= digits;
            pend_dp     <= dp_mask;
            pend_blank  <= blank_mask;
            pend        <= 1'b1;
         end else if (boundary) begin
            pend        <= 1'b0;
         end

         frame_done <= boundary;
         load_ack   <= boundary && pend;

         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose: directed self-checking bench for seg_scan_mux (REFRESH_DIV=8, GUARD_CYC=2).
// Latency: a frame is 32 cycles; outputs lag the slot counters by one cycle.
// Backpressure: n/a.
module tb_seg_scan_mux;

   logic        CLOCK;
   logic        RESET;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic [3:0]  blank_mask;
`ifdef SEG_DIM_EN
   logic [3:0]  dim_level;
`endif
   logic        load_ack;
   logic        frame_done;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks = 0;
   int errors = 0;

   // Expected anode word while slot s is lit.
   localparam logic [3:0][3:0] AN_ON = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   logic [3:0] cap_an  [32];
   logic [6:0] cap_seg [32];
   logic       cap_dp  [32];
   int         cap_stray;
   logic       cap_ack;
   logic       cap_fd;

   seg_scan_mux #(
      .REFRESH_DIV (8),
      .GUARD_CYC   (2)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .load       (load),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
`ifdef SEG_DIM_EN
      .dim_level  (dim_level),
`endif
      .load_ack   (load_ack),
      .frame_done (frame_done),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   // Runs one frame starting at a frame_done sample point; index i holds the
   // outputs for slot i/8, cycle i%8. Optional loads are driven before edge i+1.
   task automatic run_frame(input int s0, input logic [23:0] v0,
                            input int s1, input logic [23:0] v1);
      cap_stray = 0;
      for (int i = 0; i < 32; i++) begin
         if (i == s0) begin
            load = 1'b1;
            {blank_mask, dp_mask, digits} = v0;
         end else if (i == s1) begin
            load = 1'b1;
            {blank_mask, dp_mask, digits} = v1;
         end
         step();
         load = 1'b0;
         cap_an[i]  = an;
         cap_seg[i] = seg;
         cap_dp[i]  = dp;
         if (i < 31 && (load_ack || frame_done)) cap_stray++;
      end
      cap_ack = load_ack;
      cap_fd  = frame_done;
   endtask

   // es packs slot patterns {s3,s2,s1,s0}; edp is the active-low DP per slot.
   task automatic check_frame(input string tag, input logic [3:0][6:0] es,
                              input logic [3:0] edp, input logic [3:0] ebl);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            chk($sformatf("%s an s%0d c%0d", tag, s, c), cap_an[8*s+c],
                (c < 2 || ebl[s]) ? 4'hF : AN_ON[s]);
            if (c >= 2) begin
               chk($sformatf("%s seg s%0d c%0d", tag, s, c), cap_seg[8*s+c], es[s]);
               chk($sformatf("%s dp s%0d c%0d", tag, s, c), cap_dp[8*s+c], edp[s]);
            end
         end
      end
      chk($sformatf("%s fd", tag), cap_fd, 1'b1);
      chk($sformatf("%s stray pulses", tag), cap_stray, 0);
   endtask

   task automatic wait_fd(output int n, output int acks);
      n    = 0;
      acks = 0;
      do begin
         step();
         n++;
         if (load_ack) acks++;
      end while (!frame_done && n < 40);
      chk("frame_done seen", frame_done, 1'b1);
   endtask

   int n_cyc;
   int n_ack;

   initial begin
      RESET      = 1'b1;
      load       = 1'b0;
      digits     = 16'h0000;
      dp_mask    = 4'h0;
      blank_mask = 4'h0;
`ifdef SEG_DIM_EN
      dim_level  = 4'hF;
`endif

      // 1: reset values, then two blank frames with frame_done every 32 cycles
      step();
      chk("rst an", an, 4'hF);
      chk("rst seg", seg, 7'h7F);
      chk("rst dp", dp, 1'b1);
      chk("rst ack", load_ack, 1'b0);
      chk("rst fd", frame_done, 1'b0);
      step();
      step();
      RESET = 1'b0;
      wait_fd(n_cyc, n_ack);
      chk("t1 first fd cycles", n_cyc, 32);
      chk("t1 acks", n_ack, 0);
      for (int f = 0; f < 2; f++) begin
         run_frame(-1, 24'h0, -1, 24'h0);
         check_frame("t1 blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF);
         chk("t1 ack", cap_ack, 1'b0);
      end

      // 2: single load of 2024 with DP on digit 2
      run_frame(5, {4'h0, 4'b0100, 16'h2024}, -1, 24'h0);
      check_frame("t2 pre", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF);
      chk("t2 ack", cap_ack, 1'b1);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t2", {7'h24, 7'h40, 7'h24, 7'h19}, 4'b1011, 4'h0);
      chk("t2 no reack", cap_ack, 1'b0);

      // 3: two loads in one frame, latest wins, one ack
      run_frame(3, {4'h0, 4'h0, 16'h1111}, 10, {4'h0, 4'h0, 16'hABCD});
      chk("t3 ack", cap_ack, 1'b1);
      chk("t3 single ack", cap_stray, 0);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t3", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'h0);
      chk("t3 no reack", cap_ack, 1'b0);

      // 4: second load lands on the boundary while pend=1
      run_frame(5, {4'h0, 4'h0, 16'h5678}, 31, {4'h0, 4'b0001, 16'h9EF3});
      chk("t4 ack0", cap_ack, 1'b1);
      chk("t4 stray", cap_stray, 0);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t4 old", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 4'h0);
      chk("t4 ack1", cap_ack, 1'b1);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t4 new", {7'h10, 7'h06, 7'h0E, 7'h30}, 4'b1110, 4'h0);
      chk("t4 ack2", cap_ack, 1'b0);

      // 5: blank slots 1 and 3 override segments and DP
      run_frame(2, {4'b1010, 4'b1111, 16'h2103}, -1, 24'h0);
      chk("t5 ack", cap_ack, 1'b1);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t5", {7'h7F, 7'h79, 7'h7F, 7'h30}, 4'b1010, 4'b1010);
      chk("t5 no reack", cap_ack, 1'b0);

      // 6: reset in slot 2 with pending data
      load = 1'b1;
      {blank_mask, dp_mask, digits} = {4'h0, 4'h0, 16'h4444};
      step();
      load = 1'b0;
      for (int i = 0; i < 18; i++) step();
      chk("t6 pre an", an, 4'b1011);
      chk("t6 pre seg", seg, 7'h79);
      RESET = 1'b1;
      step();
      chk("t6 rst an", an, 4'hF);
      chk("t6 rst seg", seg, 7'h7F);
      chk("t6 rst dp", dp, 1'b1);
      chk("t6 rst ack", load_ack, 1'b0);
      chk("t6 rst fd", frame_done, 1'b0);
      RESET = 1'b0;
      wait_fd(n_cyc, n_ack);
      chk("t6 fd cycles", n_cyc, 32);
      chk("t6 acks", n_ack, 0);
      run_frame(-1, 24'h0, -1, 24'h0);
      check_frame("t6 post", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF);
      chk("t6 post ack", cap_ack, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
